// File: rtl/alu_seq_unit.sv
// alu_seq_unit: registered ALU with valid/ready handshakes, one-cycle logic/arith ops and a bit-serial shift-add multiplier
// Ports: clk, rst (sync, active-high)
//        in_valid/in_ready with rd1, rd2_or_imm, control_in : operand/control bundle in
//        out_valid/out_ready with alu_result, zero, op_err  : registered result bundle out
module alu_seq_unit #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2_or_imm,
  input  logic [3:0]       control_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             op_err
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] OP_MUL = 4'b1010;
  localparam int CW = SHW + 1;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] alu_r;
  logic             bad;
  logic             xfer;
  assign sh = rd2_or_imm[SHW-1:0];
  assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign xfer = in_valid && in_ready;
  assign out_valid = state_q == DONE;
  assign alu_result = res_q;
  assign zero = zero_q;
  assign op_err = err_q;
  always_comb begin
    alu_r = '0;
    bad = 1'b0;
    case (control_in)
      4'b0000: alu_r = rd1 & rd2_or_imm;
      4'b0001: alu_r = rd1 | rd2_or_imm;
      4'b0010: alu_r = rd1 + rd2_or_imm;
      4'b0110: alu_r = rd1 - rd2_or_imm;
      4'b0011: alu_r = rd1 ^ rd2_or_imm;
      4'b0100: alu_r = rd1 << sh;
      4'b0101: alu_r = rd1 >> sh;
      4'b0111: alu_r = $signed(rd1) >>> sh;
      4'b1000: alu_r = {{(WIDTH-1){1'b0}}, $signed(rd1) < $signed(rd2_or_imm)};
      4'b1001: alu_r = {{(WIDTH-1){1'b0}}, rd1 < rd2_or_imm};
      OP_MUL:  bad = 1'b0;
      default: bad = 1'b1;
    endcase
  end
  // BUSY consumes one multiplier bit per cycle; the last step (cnt_q == 1) commits the product
  always_comb begin
    state_d = state_q;
    res_d = res_q;
    zero_d = zero_q;
    err_d = err_q;
    cnt_d = cnt_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    if (state_q == BUSY) begin
      acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = DONE;
        res_d = acc_d;
        zero_d = acc_d == '0;
        err_d = 1'b0;
      end
    end else if (xfer) begin
      if (control_in == OP_MUL) begin
        state_d = BUSY;
        cnt_d = CW'(WIDTH);
        mcand_d = rd1;
        mplier_d = rd2_or_imm;
        acc_d = '0;
      end else begin
        state_d = DONE;
        res_d = alu_r;
        zero_d = alu_r == '0;
        err_d = bad;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q <= '0;
      zero_q <= 1'b1;
      err_q <= 1'b0;
      cnt_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
    end else begin
      state_q <= state_d;
      res_q <= res_d;
      zero_q <= zero_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: scoreboard-driven directed and random checks of alu_seq_unit
module tb_alu_seq_unit;
  localparam int W = 32;
  localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD_ = 4'b0010, SUB_ = 4'b0110, XOR_ = 4'b0011;
  localparam logic [3:0] SLL_ = 4'b0100, SRL_ = 4'b0101, SRA_ = 4'b0111, SLT_ = 4'b1000, SLTU_ = 4'b1001, MUL_ = 4'b1010;
  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         e;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [W-1:0] rd1 = '0;
  logic [W-1:0] rd2 = '0;
  logic [3:0] ctl = '0;
  logic in_ready, out_valid, zero, op_err;
  logic [W-1:0] alu_result;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  alu_seq_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rd1(rd1), .rd2_or_imm(rd2), .control_in(ctl),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .zero(zero), .op_err(op_err)
  );
  always #5 clk = ~clk;
  task tick;
    @(posedge clk);
    #2;
  endtask
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r, input logic e);
    exp_t x;
    in_valid = 1'b1;
    ctl = op;
    rd1 = a;
    rd2 = b;
    x.r = r;
    x.z = (r == '0);
    x.e = e;
    sb.push_back(x);
  endtask
  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [4:0] s;
    s = b[4:0];
    case (op)
      AND_: return a & b;
      OR_:  return a | b;
      ADD_: return a + b;
      SUB_: return a - b;
      XOR_: return a ^ b;
      SLL_: return a << s;
      SRL_: return a >> s;
      SRA_: return W'($signed(a) >>> s);
      SLT_: return W'($signed(a) < $signed(b));
      SLTU_: return W'(a < b);
      MUL_: return a * b;
      default: return '0;
    endcase
  endfunction
  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    tests++;
    if ({out_valid, alu_result, zero, op_err} !== {1'b0, {W{1'b0}}, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: valid=%b res=%h zero=%b err=%b want 0/0/1/0", out_valid, alu_result, zero, op_err);
    end
    rst = 1'b0;
    tick;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask
  task automatic test_add_sub;
    exp_t x;
    out_ready = 1'b1;
    issue(ADD_, 32'd10, 32'd5, 32'd15, 1'b0);
    tick;
    x = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1 || {alu_result, zero, op_err} !== x) begin
      fails++;
      $display("FAIL add: valid=%b got %h/%b/%b want %h/%b/%b", out_valid, alu_result, zero, op_err, x.r, x.z, x.e);
    end
    issue(SUB_, 32'd20, 32'd20, 32'd0, 1'b0);
    tick;
    x = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1 || {alu_result, zero, op_err} !== x) begin
      fails++;
      $display("FAIL sub_b2b: valid=%b got %h/%b/%b want %h/%b/%b", out_valid, alu_result, zero, op_err, x.r, x.z, x.e);
    end
    in_valid = 1'b0;
    tick;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL done_to_idle: out_valid %b want 0", out_valid);
    end
  endtask
  task automatic test_shift_slt;
    exp_t x;
    logic [3:0] ops [5];
    logic [W-1:0] av [5];
    logic [W-1:0] bv [5];
    logic [W-1:0] rv [5];
    ops = '{SLT_, SLTU_, SRA_, SRL_, SLL_};
    av = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h1};
    bv = '{32'h1, 32'h1, 32'h4, 32'h4, 32'h25};
    rv = '{32'h1, 32'h0, 32'hF8000000, 32'h08000000, 32'h20};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], av[i], bv[i], rv[i], 1'b0);
      tick;
      x = sb.pop_front();
      tests++;
      if (out_valid !== 1'b1 || {alu_result, zero, op_err} !== x) begin
        fails++;
        $display("FAIL shift_slt[%0d]: valid=%b got %h/%b/%b want %h/%b/%b", i, out_valid, alu_result, zero, op_err, x.r, x.z, x.e);
      end
    end
    in_valid = 1'b0;
    tick;
  endtask
  task automatic test_mul;
    exp_t x;
    bit bad;
    int n;
    out_ready = 1'b1;
    issue(MUL_, 32'h00010000, 32'h00010000, 32'h0, 1'b0);
    tick;
    bad = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
      in_valid = (i < 31);
      ctl = ADD_;
      rd1 = $urandom;
      rd2 = $urandom;
      tick;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL mul_busy: in_ready/out_valid not 0/0 during multiply");
    end
    x = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1 || {alu_result, zero, op_err} !== x) begin
      fails++;
      $display("FAIL mul_33: valid=%b got %h/%b/%b want %h/%b/%b", out_valid, alu_result, zero, op_err, x.r, x.z, x.e);
    end
    issue(MUL_, 32'hFFFFFFFF, 32'h3, 32'hFFFFFFFD, 1'b0);
    n = 1;
    tick;
    in_valid = 1'b0;
    while (!out_valid && n < 40) begin
      tick;
      n++;
    end
    x = sb.pop_front();
    tests++;
    if (n != 33 || out_valid !== 1'b1 || {alu_result, zero, op_err} !== x) begin
      fails++;
      $display("FAIL mul_wrap: latency=%0d want 33 got %h/%b/%b want %h/%b/%b", n, alu_result, zero, op_err, x.r, x.z, x.e);
    end
    tick;
  endtask
  task automatic test_backpressure;
    exp_t x;
    bit bad;
    out_ready = 1'b0;
    issue(AND_, 32'hFFFF0000, 32'h00FF00FF, 32'h00FF0000, 1'b0);
    tick;
    in_valid = 1'b1;
    ctl = XOR_;
    rd1 = 32'h12345678;
    rd2 = 32'h0F0F0F0F;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {alu_result, zero, op_err} !== sb[0]) bad = 1'b1;
      tick;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL bp_hold: valid=%b in_ready=%b res=%h want 1/0/%h", out_valid, in_ready, alu_result, sb[0].r);
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: in_ready %b want 1", in_ready);
    end
    x = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1 || {alu_result, zero, op_err} !== x) begin
      fails++;
      $display("FAIL bp_result: got %h/%b/%b want %h/%b/%b", alu_result, zero, op_err, x.r, x.z, x.e);
    end
    issue(XOR_, 32'h12345678, 32'h0F0F0F0F, 32'h1D3B5977, 1'b0);
    tick;
    x = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1 || {alu_result, zero, op_err} !== x) begin
      fails++;
      $display("FAIL bp_next: valid=%b got %h/%b/%b want %h/%b/%b", out_valid, alu_result, zero, op_err, x.r, x.z, x.e);
    end
    in_valid = 1'b0;
    tick;
  endtask
  task automatic test_abort;
    bit bad;
    out_ready = 1'b1;
    in_valid = 1'b1;
    ctl = MUL_;
    rd1 = 32'd123;
    rd2 = 32'd456;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    tests++;
    if ({out_valid, alu_result, zero, op_err} !== {1'b0, {W{1'b0}}, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL abort_state: valid=%b res=%h zero=%b err=%b want 0/0/1/0", out_valid, alu_result, zero, op_err);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_in_ready: got %b want 1", in_ready);
    end
    bad = 1'b0;
    repeat (40) begin
      tick;
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL abort_late: out_valid rose after abort");
    end
  endtask
  task automatic test_invalid;
    exp_t x;
    out_ready = 1'b1;
    issue(4'b1111, 32'd7, 32'd3, 32'd0, 1'b1);
    tick;
    x = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1 || {alu_result, zero, op_err} !== x) begin
      fails++;
      $display("FAIL invalid_op: valid=%b got %h/%b/%b want %h/%b/%b", out_valid, alu_result, zero, op_err, x.r, x.z, x.e);
    end
    issue(OR_, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'hFFFFFFFF, 1'b0);
    tick;
    x = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1 || {alu_result, zero, op_err} !== x) begin
      fails++;
      $display("FAIL or_after_invalid: valid=%b got %h/%b/%b want %h/%b/%b", out_valid, alu_result, zero, op_err, x.r, x.z, x.e);
    end
    in_valid = 1'b0;
    tick;
  endtask
  task automatic test_back_to_back;
    exp_t x;
    logic [3:0] op;
    logic [W-1:0] a, b;
    int n;
    for (int i = 0; i < 300; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL rand_unexpected: result %h with empty scoreboard", alu_result);
        end else begin
          x = sb.pop_front();
          if ({alu_result, zero, op_err} !== x) begin
            fails++;
            $display("FAIL rand[%0d]: got %h/%b/%b want %h/%b/%b", i, alu_result, zero, op_err, x.r, x.z, x.e);
          end
        end
      end
      if (in_ready && $urandom_range(0, 2) != 0) begin
        op = 4'($urandom_range(0, 15));
        if (op == MUL_ && $urandom_range(0, 3) != 0) op = ADD_;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        issue(op, a, b, model(op, a, b), op > MUL_);
      end
      tick;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      if (out_valid) begin
        x = sb.pop_front();
        tests++;
        if ({alu_result, zero, op_err} !== x) begin
          fails++;
          $display("FAIL rand_drain: got %h/%b/%b want %h/%b/%b", alu_result, zero, op_err, x.r, x.z, x.e);
        end
      end
      tick;
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL rand_timeout: %0d results outstanding, want 0", sb.size());
    end
  endtask
  initial begin
    test_reset();
    test_add_sub();
    test_shift_slt();
    test_mul();
    test_backpressure();
    test_abort();
    test_invalid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end
endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width; legal values 8, 16, 32, 64.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  operand/control bundle valid.
REQ-006 in_ready  output  1  unit can accept a bundle this cycle.
REQ-007 rd1  input  WIDTH  operand A, two's complement.
REQ-008 rd2_or_imm  input  WIDTH  operand B, two's complement.
REQ-009 control_in  input  4  operation select.
REQ-010 out_valid  output  1  result bundle valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 alu_result  output  WIDTH  registered result.
REQ-013 zero  output  1  1 when alu_result is all zeros.
REQ-014 op_err  output  1  1 when the accepted control_in was unsupported.

Function
REQ-015 Op codes SHALL be: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0011 XOR; 0100 SLL; 0101 SRL; 0111 SRA; 1000 SLT (signed); 1001 SLTU (unsigned); 1010 MUL (low WIDTH bits of the product).
REQ-016 Any other code SHALL produce alu_result 0, zero 1, op_err 1, with single-cycle latency.
REQ-017 ADD, SUB and MUL SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-018 Shift ops SHALL use rd2_or_imm[SHW-1:0] only and ignore the upper bits.
REQ-019 SLT and SLTU SHALL return 1 or 0, zero-extended to WIDTH.
REQ-020 The FSM SHALL have three states. IDLE: no result held. BUSY: multiply in progress. DONE: result held with out_valid=1.
REQ-021 A transfer SHALL occur on a cycle with in_valid && in_ready.
REQ-022 in_ready SHALL be 1 in IDLE, 0 in BUSY, and equal to out_ready in DONE.
REQ-023 When a non-MUL op is accepted, the result SHALL be registered and the FSM SHALL enter DONE on the next edge (latency 1 cycle).
REQ-024 When MUL is accepted, the unit SHALL latch both operands, enter BUSY and run a shift-add multiply at one multiplier bit per cycle, using a counter from WIDTH down to 1.
REQ-025 When the multiply counter expires, the unit SHALL enter DONE, giving out_valid exactly WIDTH+1 cycles after acceptance.
REQ-026 In DONE with out_ready=0, alu_result, zero and op_err SHALL hold stable.
REQ-027 In DONE with out_ready=1 and no new transfer, the FSM SHALL return to IDLE and out_valid SHALL drop on the next edge.
REQ-028 In DONE with out_ready=1 and a new transfer, the unit SHALL enter DONE (non-MUL) or BUSY (MUL) directly, giving a throughput of one non-MUL op per cycle.
REQ-029 zero and op_err SHALL be registered together with alu_result, never computed combinationally from live inputs.
REQ-030 Inputs SHALL be ignored while in BUSY; operands latched at acceptance SHALL NOT be affected by later input changes.
REQ-031 outputs SHALL be a function of state registers only; there SHALL be no combinational path from in_* to out_*.

Reset
REQ-032 When rst=1 at a clock edge, the unit SHALL enter IDLE with out_valid 0, alu_result 0, zero 1, op_err 0, and the multiply counter and operand registers cleared.
REQ-033 rst SHALL take priority over any transfer or multiply step in the same cycle; an in-flight MUL SHALL be discarded with no result produced.
REQ-034 in_ready SHALL be 1 in the cycle after rst deasserts.

Verification (WIDTH=32)
REQ-035 ADD 10+5, out_ready=1 -> out_valid one cycle after accept, result 15, zero 0, op_err 0; then SUB 20-20 issued back-to-back -> next cycle result 0, zero 1.
REQ-036 SLT 0xFFFFFFFF vs 1 -> result 1; SLTU with the same operands -> result 0; SRA 0x80000000 by 4 -> 0xF8000000; SRL with the same operands -> 0x08000000; SLL 1 by 0x25 -> 0x20 (upper shift bits ignored).
REQ-037 MUL 0x00010000 × 0x00010000 -> in_ready 0 for 32 cycles, out_valid exactly 33 cycles after accept, result 0, zero 1; MUL 0xFFFFFFFF × 3 -> 0xFFFFFFFD.
REQ-038 Backpressure: hold out_ready=0 for 3 cycles after AND 0xFFFF0000 & 0x00FF00FF -> 0x00FF0000 held stable, in_ready 0 throughout; raise out_ready -> transfer completes.
REQ-039 Abort: assert rst 5 cycles into a MUL -> next cycle out_valid 0, alu_result 0, zero 1, no late result; after rst deasserts, in_ready 1.
REQ-040 Invalid control_in 1111 with operands 7, 3 -> result 0, zero 1, op_err 1; a following OR 0x0F0F0F0F | 0xF0F0F0F0 -> 0xFFFFFFFF, op_err 0.
